// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Multi-channel conditioning bank for switches and push-buttons. Every channel
// is independent and has:
//   - a SYNC_STAGES-deep synchroniser,
//   - a debounce counter that accepts a new level after STABLE_CYCLES
//     consecutive samples that disagree with the current level,
//   - one-cycle rise/fall pulses,
//   - a hold FSM (IDLE/HOLD/REPEAT) that produces a long_press pulse after
//     LONG_PRESS_CYCLES of held-high level, then repeat_pulse every
//     REPEAT_CYCLES while the level stays high.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   raw_in        in   [CHANNELS] asynchronous raw levels
//   level_out     out  [CHANNELS] debounced level
//   rise_pulse    out  [CHANNELS] one-cycle pulse on level 0->1
//   fall_pulse    out  [CHANNELS] one-cycle pulse on level 1->0
//   long_press    out  [CHANNELS] one-cycle pulse after LONG_PRESS_CYCLES high
//   repeat_pulse  out  [CHANNELS] one-cycle pulse every REPEAT_CYCLES afterwards
//
// All outputs come straight from flops; nothing combinational reaches them
// from raw_in.
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int CHANNELS          = 21,
    parameter int SYNC_STAGES       = 2,
    parameter int STABLE_CYCLES     = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter int REPEAT_CYCLES     = 25000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int DW       = (STABLE_CYCLES >= 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam int HW       = (HOLD_MAX >= 1) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [DW-1:0] STABLE_T = DW'(STABLE_CYCLES);
    localparam logic [HW-1:0] LONG_T   = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] REPEAT_T = HW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_e;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_s;

    logic [DW-1:0]       deb_cnt_q  [CHANNELS];
    logic [DW-1:0]       deb_cnt_d  [CHANNELS];
    logic [HW-1:0]       hold_cnt_q [CHANNELS];
    logic [HW-1:0]       hold_cnt_d [CHANNELS];
    hold_state_e         state_q    [CHANNELS];
    hold_state_e         state_d    [CHANNELS];

    logic [CHANNELS-1:0] level_q,  level_d;
    logic [CHANNELS-1:0] rise_q,   rise_d;
    logic [CHANNELS-1:0] fall_q,   fall_d;
    logic [CHANNELS-1:0] long_q,   long_d;
    logic [CHANNELS-1:0] repeat_q, repeat_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain: stage 0 samples raw_in, each later stage copies the previous one.
    always_comb begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
            if (k == 0) begin
                sync_d[k] = raw_in;
            end else begin
                sync_d[k] = sync_q[k-1];
            end
        end
    end

    // Per-channel debounce and hold FSM next-state logic.
    always_comb begin
        level_d  = level_q;
        rise_d   = '0;
        fall_d   = '0;
        long_d   = '0;
        repeat_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            deb_cnt_d[i]  = '0;
            hold_cnt_d[i] = hold_cnt_q[i];
            state_d[i]    = state_q[i];

            // Debounce: count disagreeing samples, flip the level on the terminal count.
            if (sync_s[i] != level_q[i]) begin
                if ((deb_cnt_q[i] + DW'(1)) == STABLE_T) begin
                    level_d[i]   = ~level_q[i];
                    rise_d[i]    = ~level_q[i];
                    fall_d[i]    = level_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end

            // Hold FSM reacts to the level change on the same edge it happens,
            // so a release suppresses a pulse due on that very edge.
            if (fall_d[i]) begin
                state_d[i]    = ST_IDLE;
                hold_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        hold_cnt_d[i] = '0;
                        if (rise_d[i]) begin
                            state_d[i] = ST_HOLD;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if ((hold_cnt_q[i] + HW'(1)) == LONG_T) begin
                            long_d[i]     = 1'b1;
                            hold_cnt_d[i] = '0;
                            state_d[i]    = ST_REPEAT;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if ((hold_cnt_q[i] + HW'(1)) == REPEAT_T) begin
                            repeat_d[i]   = 1'b1;
                            hold_cnt_d[i] = '0;
                        end else begin
                            hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                        end
                    end
                    default: begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // State registers with synchronous reset taking priority over every update.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
                state_q[i]    <= ST_IDLE;
            end
            level_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            long_q   <= '0;
            repeat_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign level_out    = level_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for input_conditioner with CHANNELS=4,
// SYNC_STAGES=2, STABLE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3.
// Edge numbers in comments count from edge 1, the first edge that samples the
// new raw_in value. Outputs are sampled 1 time unit after each rising edge and
// new inputs are applied at that same point.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] level_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] long_press;
    logic [3:0] repeat_pulse;

    int n_cmp;
    int n_err;
    int rise_cnt;

    input_conditioner #(
        .CHANNELS          (4),
        .SYNC_STAGES       (2),
        .STABLE_CYCLES     (4),
        .LONG_PRESS_CYCLES (10),
        .REPEAT_CYCLES     (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .raw_in       (raw_in),
        .level_out    (level_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        raw_in = 4'b0000;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rise_cnt = 0;
        reset    = 1'b1;
        raw_in   = 4'b0000;

        // Reset state
        tick();
        tick();
        chk("reset_level",  32'(level_out),    32'h0);
        chk("reset_rise",   32'(rise_pulse),   32'h0);
        chk("reset_fall",   32'(fall_pulse),   32'h0);
        chk("reset_long",   32'(long_press),   32'h0);
        chk("reset_repeat", 32'(repeat_pulse), 32'h0);
        reset = 1'b0;

        // Clean press on channel 0: level and rise after edge 6 only.
        raw_in = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("clean_level", 32'(level_out),  (e >= 6) ? 32'h1 : 32'h0);
            chk("clean_rise",  32'(rise_pulse), (e == 6) ? 32'h1 : 32'h0);
        end

        // Glitch of 3 edges on channel 1 never changes anything.
        do_reset();
        raw_in = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) raw_in = 4'b0000;
            tick();
            chk("glitch_outs", 32'({level_out[1], rise_pulse[1], fall_pulse[1]}), 32'h0);
        end

        // Bounce 1,0,1,0 then steady 1 from edge 5 on channel 2: rise after edge 10.
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            if (e == 1 || e == 3 || e >= 5) raw_in = 4'b0100;
            else                             raw_in = 4'b0000;
            tick();
            if (rise_pulse[2]) rise_cnt++;
            chk("bounce_level", 32'(level_out),  (e >= 10) ? 32'h4 : 32'h0);
            chk("bounce_rise",  32'(rise_pulse), (e == 10) ? 32'h4 : 32'h0);
        end
        chk("bounce_rise_count", 32'(rise_cnt), 32'd1);

        // Long press / repeat on channel 3: rise at 6, long at 16, repeats 19,22,25,28.
        // Raw released from edge 26 -> fall at 31, where the due repeat is suppressed.
        do_reset();
        raw_in = 4'b1000;
        for (int e = 1; e <= 40; e++) begin
            if (e == 26) raw_in = 4'b0000;
            tick();
            chk("lp_long", 32'(long_press), (e == 16) ? 32'h8 : 32'h0);
            chk("lp_repeat", 32'(repeat_pulse),
                (e == 19 || e == 22 || e == 25 || e == 28) ? 32'h8 : 32'h0);
            chk("lp_fall",  32'(fall_pulse), (e == 31) ? 32'h8 : 32'h0);
            chk("lp_level", 32'(level_out),  (e >= 6 && e <= 30) ? 32'h8 : 32'h0);
        end

        // Reset mid-operation: ch0 rises at 6, long at 16, REPEAT counter 2 after edge 18.
        do_reset();
        raw_in = 4'b0001;
        for (int e = 1; e <= 18; e++) begin
            tick();
        end
        chk("mid_pre_level", 32'(level_out), 32'h1);
        reset = 1'b1;
        tick();
        chk("mid_rst_level",  32'(level_out),    32'h0);
        chk("mid_rst_pulses", 32'({rise_pulse, fall_pulse, long_press, repeat_pulse}), 32'h0);
        reset = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("mid_level",  32'(level_out),  (e >= 6) ? 32'h1 : 32'h0);
            chk("mid_rise",   32'(rise_pulse), (e == 6) ? 32'h1 : 32'h0);
            chk("mid_long",   32'(long_press), (e == 16) ? 32'h1 : 32'h0);
            chk("mid_repeat", 32'(repeat_pulse), (e == 19) ? 32'h1 : 32'h0);
            chk("mid_fall",   32'(fall_pulse), 32'h0);
        end

        // Simultaneous press and release: 0011 -> 1100 sampled at edge 7, swap at edge 12.
        do_reset();
        raw_in = 4'b0011;
        for (int e = 1; e <= 13; e++) begin
            if (e == 7) raw_in = 4'b1100;
            tick();
            chk("sim_level", 32'(level_out),
                (e >= 12) ? 32'hC : ((e >= 6) ? 32'h3 : 32'h0));
            chk("sim_rise", 32'(rise_pulse),
                (e == 12) ? 32'hC : ((e == 6) ? 32'h3 : 32'h0));
            chk("sim_fall", 32'(fall_pulse), (e == 12) ? 32'h3 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel input conditioning block for the stopwatch/leaderboard design. It replaces the per-signal debouncer instances on switches and push-buttons with one CHANNELS-wide bank. Each channel has a synchroniser, a debounce counter, edge pulses, long-press detection and auto-repeat. Outputs feed the mode logic, the stopwatch control and the leaderboard.

## Interface
- CHANNELS, 21, number of independent input channels (16 switches + 5 buttons)
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (≥2)
- STABLE_CYCLES, 1000000, consecutive cycles of disagreement needed to accept a new level (≥1; 10 ms at 100 MHz)
- LONG_PRESS_CYCLES, 100000000, cycles a debounced level must stay high before long_press fires (≥1)
- REPEAT_CYCLES, 25000000, auto-repeat period after long press (≥1)
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- raw_in  input  CHANNELS  asynchronous raw switch/button levels
- level_out  output  CHANNELS  debounced level per channel
- rise_pulse  output  CHANNELS  one-cycle pulse when level_out goes 0→1
- fall_pulse  output  CHANNELS  one-cycle pulse when level_out goes 1→0
- long_press  output  CHANNELS  one-cycle pulse when level_out has been high for LONG_PRESS_CYCLES
- repeat_pulse  output  CHANNELS  one-cycle pulse every REPEAT_CYCLES after long_press while still high

## Operation
- Channels are fully independent; there is no shared state between channels.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops. The last stage is s[i].
- Debounce counter: width $clog2(STABLE_CYCLES+1).
  - On each edge with s[i] != level_out[i], the counter increments.
  - On each edge with s[i] == level_out[i], the counter clears to 0. A glitch shorter than STABLE_CYCLES therefore never changes level_out.
  - When the increment would reach STABLE_CYCLES: level_out[i] inverts, the counter clears, and the matching rise_pulse[i] or fall_pulse[i] asserts for exactly that one cycle.
- Hold counter: width $clog2(max(LONG_PRESS_CYCLES, REPEAT_CYCLES)+1).
  - Per-channel FSM with states IDLE, HOLD and REPEAT.
  - IDLE → HOLD when level_out rises; the counter is cleared.
  - HOLD: the counter increments every cycle. When the count reaches LONG_PRESS_CYCLES, long_press pulses for one cycle, the counter clears and the FSM goes to REPEAT.
  - REPEAT: the counter increments. When it reaches REPEAT_CYCLES, repeat_pulse pulses for one cycle and the counter clears.
  - Any state → IDLE in the same cycle level_out falls; the counter clears. A release therefore suppresses any pending long_press or repeat_pulse.
- Counters never wrap; each one clears exactly at its terminal count.
- rise_pulse, fall_pulse, long_press and repeat_pulse are registered outputs with no combinational path from raw_in.

## Timing
- Reset values: all synchroniser flops 0, level_out 0, all counters 0, all FSMs IDLE, all pulse outputs 0.
- Reset has priority over every other event. Reset asserted mid-count or mid-hold discards progress; no pulse is emitted on the reset edge or on the cycle after it.
- Debounce latency: number edges from edge 1, the first edge that samples a new stable raw value.
  - level_out and the edge pulse change after edge SYNC_STAGES+STABLE_CYCLES.
  - Example: SYNC_STAGES=2, STABLE_CYCLES=4 gives edge 6.
- Long press: if level_out rises after edge E, long_press is high in the cycle after edge E+LONG_PRESS_CYCLES.
- Repeat: the first repeat_pulse follows long_press by REPEAT_CYCLES cycles; later pulses are spaced REPEAT_CYCLES apart.
- Rise and long_press never assert in the same cycle on one channel, because LONG_PRESS_CYCLES ≥ 1.
- An input held high through reset release counts as a new press and incurs the full debounce latency.
- Simultaneous events on different channels are handled independently, in the same cycle.

## Test plan
Use CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3.
- **Clean press:** after reset, raw_in=4'b0001 from edge 1 → level_out[0]=1 and rise_pulse[0]=1 after edge 6 only; rise_pulse[0]=0 after edge 7; other channels stay 0.
- **Glitch rejection:** raw_in[1] high for 3 edges, then low → level_out[1], rise_pulse[1] and fall_pulse[1] stay 0 throughout.
- **Bounce, then settle:** raw_in[2] toggles 1,0,1,0, then stays 1 from edge 5 → level_out[2] rises after edge 10, with exactly one rise_pulse.
- **Long press and repeat:** level_out[3] rises after edge E → long_press[3] after E+10; repeat_pulse[3] after E+13, E+16, E+19. Release → fall_pulse[3] after 6 edges, with no further repeats.
- **Reset mid-operation:** assert reset while channel 0 is high in REPEAT with the counter at 2, raw still high. Required response:
  - All outputs are 0 after the reset edge.
  - After deassert, level_out[0] returns to 1 with full latency.
  - long_press[0] fires 10 cycles after that rise.
- **Simultaneous press and release:** raw_in 4'b0011→4'b1100 in one cycle → fall_pulse[1:0] and rise_pulse[3:2] all assert in the same cycle.
